gold_seed_scheduler: RTL and testbench

GOLD_SEED_SCHEDULER -- requirements
Module: gold_seed_scheduler

---
 rtl/gold_ctrl_pkg.sv | 7 +
 rtl/axistream_if.sv | 9 +
 rtl/gold_rr_arbiter.sv | 28 ++
 rtl/gold_seed_scheduler.sv | 98 +++++++++
 tb/tb_gold_seed_scheduler.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gold_ctrl_pkg.sv
// gold_ctrl_pkg: shared FSM state type and default sizing for the Gold seed scheduler.
package gold_ctrl_pkg;
  localparam int DEF_N = 63;
  localparam int DEF_LENGTH = $clog2(DEF_N);
  localparam int DEF_NREQ = 4;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_RUN, ST_DONE} state_t;
endpackage

// File: rtl/axistream_if.sv
// axistream_if: minimal AXI-stream bundle carrying a seed pair (tdata = seed2, tuser = seed1).
interface axistream_if #(parameter int DW = 6, parameter int UW = 6) ();
  logic tvalid;
  logic tready;
  logic [DW-1:0] tdata;
  logic [UW-1:0] tuser;
  modport master (output tvalid, output tdata, output tuser, input tready);
  modport slave (input tvalid, input tdata, input tuser, output tready);
endinterface

// File: rtl/gold_rr_arbiter.sv
// gold_rr_arbiter: round-robin search starting after the last advanced winner.
module gold_rr_arbiter #(
  parameter int NREQ = 4
) (
  input  logic            clkin,
  input  logic            rstn,
  input  logic [NREQ-1:0] req,
  input  logic            adv,
  output logic [NREQ-1:0] win,
  output logic            any
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  logic [IW-1:0] ptr, nxt;
  always_comb begin
    win = '0;
    any = 1'b0;
    nxt = ptr;
    for (int i = 0; i < NREQ; i++)
      if (!any && req[(int'(ptr) + i) % NREQ]) begin
        win[(int'(ptr) + i) % NREQ] = 1'b1;
        nxt = IW'((int'(ptr) + i + 1) % NREQ);
        any = 1'b1;
      end
  end
  always_ff @(posedge clkin or negedge rstn)
    if (!rstn) ptr <= '0;
    else if (adv) ptr <= nxt;
endmodule

// File: rtl/gold_seed_scheduler.sv
// gold_seed_scheduler: grants the Gold generator to one channel per code period and forwards its chips.
module gold_seed_scheduler
  import gold_ctrl_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int LENGTH = $clog2(N),
  parameter int NREQ = DEF_NREQ
) (
  input  logic                         clkin,
  input  logic                         rstn,
  input  logic [NREQ-1:0]              req_i,
  input  logic [NREQ-1:0][LENGTH-1:0]  seed1_i,
  input  logic [NREQ-1:0][LENGTH-1:0]  seed2_i,
  axistream_if.master                  m_axis,
  input  logic                         strobe_sig_i,
  input  logic                         code_gold_i,
  output logic [NREQ-1:0]              grant_o,
  output logic                         chip_o,
  output logic                         chip_valid_o,
  output logic [(NREQ > 1 ? $clog2(NREQ) : 1)-1:0] chip_ch_o,
  output logic [NREQ-1:0]              done_o,
  output logic [NREQ-1:0]              seed_err_o
);
  localparam int IW = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(N + 1);
  state_t st;
  logic [CW-1:0] cnt;
  logic [IW-1:0] own, win_idx;
  logic [NREQ-1:0] win_oh;
  logic any, bad, lost;
  gold_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clkin(clkin),
    .rstn(rstn),
    .req(req_i),
    .adv(st == ST_IDLE && any),
    .win(win_oh),
    .any(any)
  );
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++)
      if (win_oh[i]) win_idx = IW'(i);
  end
  assign bad = seed1_i[win_idx] == '0 || seed2_i[win_idx] == '0;
  assign lost = ~|(req_i & grant_o);
  always_ff @(posedge clkin or negedge rstn)
    if (!rstn) begin
      st <= ST_IDLE;
      cnt <= '0;
      own <= '0;
      m_axis.tvalid <= 1'b0;
      m_axis.tdata <= '0;
      m_axis.tuser <= '0;
      grant_o <= '0;
      chip_o <= 1'b0;
      chip_valid_o <= 1'b0;
      chip_ch_o <= '0;
      done_o <= '0;
      seed_err_o <= '0;
    end else begin
      chip_valid_o <= 1'b0;
      done_o <= '0;
      seed_err_o <= '0;
      case (st)
        ST_IDLE:
          if (any && bad) seed_err_o <= win_oh;
          else if (any) begin
            st <= ST_LOAD;
            own <= win_idx;
            grant_o <= win_oh;
            m_axis.tvalid <= 1'b1;
            m_axis.tdata <= seed2_i[win_idx];
            m_axis.tuser <= seed1_i[win_idx];
          end
        ST_LOAD, ST_RUN:
          if (lost) begin
            st <= ST_DONE;
            cnt <= '0;
            grant_o <= '0;
            m_axis.tvalid <= 1'b0;
          end else if (st == ST_LOAD) begin
            if (m_axis.tready) st <= ST_RUN;
          end else if (strobe_sig_i) begin
            chip_o <= code_gold_i;
            chip_valid_o <= 1'b1;
            chip_ch_o <= own;
            cnt <= cnt == CW'(N - 1) ? '0 : cnt + 1'b1;
            if (cnt == CW'(N - 1)) begin
              st <= ST_DONE;
              done_o <= grant_o;
              grant_o <= '0;
              m_axis.tvalid <= 1'b0;
            end
          end
        default: st <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_gold_seed_scheduler.sv
// tb_gold_seed_scheduler: directed scenarios plus random traffic against a session-level reference model.
module tb_gold_seed_scheduler;
  localparam int N = 63;
  localparam int L = 6;
  localparam int NR = 4;
  localparam int IW = 2;
  logic clkin = 1'b0;
  logic rstn = 1'b1;
  logic [NR-1:0] req_i = '0;
  logic [NR-1:0][L-1:0] seed1_i = '0;
  logic [NR-1:0][L-1:0] seed2_i = '0;
  logic strobe_sig_i = 1'b0;
  logic code_gold_i = 1'b0;
  logic [NR-1:0] grant_o, done_o, seed_err_o;
  logic chip_o, chip_valid_o;
  logic [IW-1:0] chip_ch_o;
  axistream_if #(.DW(L), .UW(L)) m_axis ();
  gold_seed_scheduler #(.N(N), .LENGTH(L), .NREQ(NR)) dut (
    .clkin(clkin),
    .rstn(rstn),
    .req_i(req_i),
    .seed1_i(seed1_i),
    .seed2_i(seed2_i),
    .m_axis(m_axis),
    .strobe_sig_i(strobe_sig_i),
    .code_gold_i(code_gold_i),
    .grant_o(grant_o),
    .chip_o(chip_o),
    .chip_valid_o(chip_valid_o),
    .chip_ch_o(chip_ch_o),
    .done_o(done_o),
    .seed_err_o(seed_err_o)
  );
  always #5 clkin = ~clkin;
  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;
  // Reference model: one session per owner, tracked as owner / handshake seen / chips delivered.
  int owner = -1;
  int chips = 0;
  int rr = 0;
  int found = -1;
  bit started = 1'b0;
  bit cool = 1'b0;
  logic [NR-1:0] e_grant = '0, e_done = '0, e_err = '0;
  logic e_tv = 1'b0, e_cv = 1'b0, e_chip = 1'b0;
  logic [L-1:0] e_td = '0, e_tu = '0;
  logic [IW-1:0] e_ch = '0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h @%0t", nm, act, exp, $time);
    end
  endtask
  always @(posedge clkin or negedge rstn)
    if (!rstn) begin
      owner = -1; chips = 0; rr = 0; started = 0; cool = 0;
      e_grant = '0; e_done = '0; e_err = '0; e_tv = 0; e_cv = 0; e_chip = 0;
      e_td = '0; e_tu = '0; e_ch = '0;
    end else begin
      e_cv = 0; e_done = '0; e_err = '0;
      if (cool) cool = 0;
      else if (owner < 0) begin
        found = -1;
        for (int i = 0; i < NR; i++)
          if (found < 0 && req_i[(rr + i) % NR]) found = (rr + i) % NR;
        if (found >= 0) begin
          rr = (found + 1) % NR;
          if (seed1_i[found] == 0 || seed2_i[found] == 0) e_err[found] = 1'b1;
          else begin
            owner = found; started = 0; chips = 0;
            e_grant = '0; e_grant[owner] = 1'b1; e_tv = 1;
            e_td = seed2_i[owner]; e_tu = seed1_i[owner];
          end
        end
      end else if (!req_i[owner]) begin
        owner = -1; cool = 1; e_grant = '0; e_tv = 0;
      end else if (!started) started = m_axis.tready;
      else if (strobe_sig_i) begin
        chips++; e_cv = 1; e_chip = code_gold_i; e_ch = IW'(owner);
        if (chips == N) begin
          e_done = e_grant; owner = -1; cool = 1; e_grant = '0; e_tv = 0;
        end
      end
    end
  always @(negedge clkin)
    if (chk_en) begin
      chk("grant", grant_o, e_grant);
      chk("tvalid", m_axis.tvalid, e_tv);
      chk("tdata", m_axis.tdata, e_td);
      chk("tuser", m_axis.tuser, e_tu);
      chk("chip_valid", chip_valid_o, e_cv);
      chk("chip", chip_o, e_chip);
      chk("chip_ch", chip_ch_o, e_ch);
      chk("done", done_o, e_done);
      chk("seed_err", seed_err_o, e_err);
    end
  task automatic do_reset;
    @(negedge clkin);
    #2 rstn = 1'b0;
    req_i = '0; strobe_sig_i = 0; code_gold_i = 0; m_axis.tready = 0;
    for (int k = 0; k < NR; k++) begin
      seed1_i[k] = L'(k + 1);
      seed2_i[k] = L'(k + 9);
    end
    #1 rstn = 1'b1;
  endtask
  task automatic wait_chips(input int ch, input int target, output int got);
    got = 0;
    for (int c = 0; c < 300 && got < target; c++) begin
      @(negedge clkin);
      code_gold_i = 1'($urandom);
      if (chip_valid_o && chip_ch_o == IW'(ch)) got++;
    end
  endtask
  int nch, gcyc, ndone, got;
  logic [NR-1:0] dval, prev;
  int ord[$];
  int chips_per[NR];
  int exp_ord[5] = '{0, 1, 2, 3, 0};
  initial begin
    m_axis.tready = 1'b0;
    do_reset;
    chk_en = 1'b1;
    // single request, full period
    seed1_i[0] = 6'b000011; seed2_i[0] = 6'b100111;
    m_axis.tready = 1; strobe_sig_i = 1; req_i = 4'b0001;
    nch = 0; gcyc = 0; ndone = 0; dval = '0;
    for (int c = 0; c < 200 && ndone == 0; c++) begin
      @(negedge clkin);
      code_gold_i = 1'($urandom);
      if (chip_valid_o && chip_ch_o == 0) nch++;
      if (grant_o == 4'b0001) gcyc++;
      if (done_o != 0) begin ndone++; dval = done_o; end
    end
    req_i = '0;
    chk("single_chips", nch, 63);
    chk("single_grant_cycles", gcyc, 64);
    chk("single_done", dval, 4'b0001);
    @(negedge clkin);
    @(negedge clkin);
    chk("single_idle_tvalid", m_axis.tvalid, 0);
    // fairness with all channels requesting
    do_reset;
    req_i = 4'b1111; m_axis.tready = 1; strobe_sig_i = 1; prev = '0;
    for (int k = 0; k < NR; k++) chips_per[k] = 0;
    for (int c = 0; c < 800 && ord.size() < 5; c++) begin
      @(negedge clkin);
      code_gold_i = 1'($urandom);
      if (grant_o != 0 && grant_o != prev) ord.push_back($clog2(grant_o));
      prev = grant_o;
      if (chip_valid_o && ord.size() < 5) chips_per[chip_ch_o]++;
    end
    chk("fair_grants", ord.size(), 5);
    for (int i = 0; i < 5; i++) chk("fair_order", i < ord.size() ? ord[i] : 99, exp_ord[i]);
    for (int k = 0; k < NR; k++) chk("fair_chips", chips_per[k], 63);
    // back-pressure in LOAD
    do_reset;
    seed1_i[1] = 6'h15; seed2_i[1] = 6'h2a; req_i = 4'b0010;
    @(negedge clkin);
    for (int i = 0; i < 10; i++) begin
      chk("bp_tvalid", m_axis.tvalid, 1);
      chk("bp_tdata", m_axis.tdata, 6'h2a);
      chk("bp_tuser", m_axis.tuser, 6'h15);
      seed1_i = NR * L'($urandom);
      seed2_i = NR * L'($urandom);
      @(negedge clkin);
    end
    m_axis.tready = 1; strobe_sig_i = 1;
    @(negedge clkin);
    chk("bp_run_no_chip", chip_valid_o, 0);
    @(negedge clkin);
    chk("bp_first_chip", chip_valid_o, 1);
    req_i = '0;
    // locked seed is rejected
    do_reset;
    seed1_i[2] = '0; seed2_i[2] = 6'h11; req_i = 4'b0100; m_axis.tready = 1;
    @(negedge clkin);
    chk("bad_err", seed_err_o, 4'b0100);
    chk("bad_grant", grant_o, 0);
    chk("bad_tvalid", m_axis.tvalid, 0);
    req_i = '0;
    @(negedge clkin);
    chk("bad_err_clear", seed_err_o, 0);
    // owner drops its request mid-period
    do_reset;
    req_i = 4'b0010; m_axis.tready = 1; strobe_sig_i = 1;
    wait_chips(1, 20, got);
    chk("abort_reach", got, 20);
    req_i = 4'b1000;
    @(negedge clkin);
    chk("abort_tvalid", m_axis.tvalid, 0);
    chk("abort_grant", grant_o, 0);
    chk("abort_done", done_o, 0);
    @(negedge clkin);
    @(negedge clkin);
    chk("abort_next_grant", grant_o, 4'b1000);
    chk("abort_next_tvalid", m_axis.tvalid, 1);
    // asynchronous reset mid-period
    do_reset;
    req_i = 4'b0100; m_axis.tready = 1; strobe_sig_i = 1;
    wait_chips(2, 30, got);
    chk("rst_reach", got, 30);
    #2 rstn = 1'b0;
    #1;
    chk("rst_grant", grant_o, 0);
    chk("rst_tvalid", m_axis.tvalid, 0);
    chk("rst_tdata", m_axis.tdata, 0);
    chk("rst_tuser", m_axis.tuser, 0);
    chk("rst_chip_valid", chip_valid_o, 0);
    chk("rst_chip", chip_o, 0);
    chk("rst_chip_ch", chip_ch_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", seed_err_o, 0);
    @(negedge clkin);
    rstn = 1'b1; req_i = 4'b1111;
    @(negedge clkin);
    chk("rst_restart_grant", grant_o, 4'b0001);
    // random traffic
    do_reset;
    req_i = NR'($urandom);
    for (int c = 0; c < 30000; c++) begin
      @(negedge clkin);
      for (int k = 0; k < NR; k++)
        if ($urandom_range(0, 299) == 0) req_i[k] = ~req_i[k];
      seed1_i[$urandom_range(0, NR - 1)] = $urandom_range(0, 15) == 0 ? '0 : L'($urandom);
      seed2_i[$urandom_range(0, NR - 1)] = $urandom_range(0, 15) == 0 ? '0 : L'($urandom);
      m_axis.tready = $urandom_range(0, 3) != 0;
      strobe_sig_i = $urandom_range(0, 2) != 0;
      code_gold_i = 1'($urandom);
      if ($urandom_range(0, 1999) == 0) begin
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
      end
    end
    @(negedge clkin);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
